// File: rtl/pe_line_sad.sv
// Eight-PE row of a block-matching SAD engine: reference pixels shift through an
// 8-deep chain, absolute differences are registered, then summed into result_reg.
module pe_line_sad (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in_cur0,
    input  logic [7:0]  data_in_cur1,
    input  logic [7:0]  data_in_cur2,
    input  logic [7:0]  data_in_cur3,
    input  logic [7:0]  data_in_cur4,
    input  logic [7:0]  data_in_cur5,
    input  logic [7:0]  data_in_cur6,
    input  logic [7:0]  data_in_cur7,
    input  logic [7:0]  data_in_ref,
    output logic [10:0] result_reg
);

    logic [7:0] sr  [8];
    logic [7:0] ad  [8];
    logic [7:0] cur [8];
    logic [7:0] ad_next [8];

    assign cur[0] = data_in_cur0;
    assign cur[1] = data_in_cur1;
    assign cur[2] = data_in_cur2;
    assign cur[3] = data_in_cur3;
    assign cur[4] = data_in_cur4;
    assign cur[5] = data_in_cur5;
    assign cur[6] = data_in_cur6;
    assign cur[7] = data_in_cur7;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) sr[k] <= 8'd0;
        end else begin
            sr[0] <= data_in_ref;
            for (int k = 1; k < 8; k++) sr[k] <= sr[k-1];
        end
    end

    // PE i sees sr[7-i], so PE0 holds the oldest sample and the window order matches cur0..cur7
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ad_next[i] = 8'd0;
            if (cur[i] >= sr[7-i]) ad_next[i] = cur[i] - sr[7-i];
            else                   ad_next[i] = sr[7-i] - cur[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) ad[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) ad[i] <= ad_next[i];
        end
    end

    logic [8:0]  sum_l1 [4];
    logic [9:0]  sum_l2 [2];
    logic [10:0] sum_l3;

    // 8 x 255 = 2040 fits in 11 bits, so the tree never overflows
    always_comb begin
        for (int j = 0; j < 4; j++) sum_l1[j] = {1'b0, ad[2*j]} + {1'b0, ad[2*j+1]};
        for (int j = 0; j < 2; j++) sum_l2[j] = {1'b0, sum_l1[2*j]} + {1'b0, sum_l1[2*j+1]};
        sum_l3 = {1'b0, sum_l2[0]} + {1'b0, sum_l2[1]};
    end

    always_ff @(posedge clk) begin
        if (rst) result_reg <= 11'd0;
        else     result_reg <= sum_l3;
    end

endmodule

// File: tb/tb_pe_line_sad.sv
// Directed bench for pe_line_sad: a vector table of per-edge stimulus with
// hand-computed results, plus impulse sequences for cur/ref propagation.
module tb_pe_line_sad;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cur;
    logic [7:0]  ref_px;
    logic [10:0] result_reg;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic        rst;
        logic [63:0] cur;
        logic [7:0]  ref_px;
        logic        chk;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    pe_line_sad dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_cur0 (cur[7:0]),
        .data_in_cur1 (cur[15:8]),
        .data_in_cur2 (cur[23:16]),
        .data_in_cur3 (cur[31:24]),
        .data_in_cur4 (cur[39:32]),
        .data_in_cur5 (cur[47:40]),
        .data_in_cur6 (cur[55:48]),
        .data_in_cur7 (cur[63:56]),
        .data_in_ref  (ref_px),
        .result_reg   (result_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] splat(input logic [7:0] c);
        return {8{c}};
    endfunction

    function automatic int min8(input int v);
        return (v < 8) ? v : 8;
    endfunction

    task automatic add(input logic r, input logic [63:0] c, input logic [7:0] rp,
                       input logic chk, input int exp, input string name);
        vec_t v;
        v.rst = r; v.cur = c; v.ref_px = rp; v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic tick(input logic r, input logic [63:0] c, input logic [7:0] rp);
        rst = r; cur = c; ref_px = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int exp);
        check_cnt++;
        if (int'(result_reg) == exp) pass_cnt++;
        else $display("FAIL %s: result_reg=%0d expected %0d", name, result_reg, exp);
    endtask

    task automatic check_internal_zero(input string name);
        logic [7:0] acc;
        acc = 8'd0;
        for (int k = 0; k < 8; k++) acc = acc | dut.sr[k] | dut.ad[k];
        check_cnt++;
        if (acc == 8'd0) pass_cnt++;
        else $display("FAIL %s: internal OR=%0h expected 0", name, acc);
    endtask

    initial begin
        logic [63:0] ramp;
        ramp = 64'h0706050403020100;
        rst = 1'b1; cur = '0; ref_px = '0;

        // reset held with arbitrary inputs
        for (int k = 0; k < 3; k++) add(1, splat(8'd200), 8'd77, 1, 0, "reset_hold");

        // constant stream cur=1 ref=0
        add(0, splat(8'd1), 8'd0, 1, 0, "const_e1");
        for (int k = 0; k < 4; k++) add(0, splat(8'd1), 8'd0, 1, 8, "const");

        // full-scale fill, then mid-stream reset and refill
        for (int pass = 0; pass < 2; pass++) begin
            add(1, splat(8'd0), 8'd255, 1, 0, pass == 0 ? "full_rst" : "mid_rst");
            for (int k = 1; k <= 12; k++)
                add(0, splat(8'd0), 8'd255, 1, (k < 2) ? 0 : 255 * min8(k - 2),
                    pass == 0 ? "full_fill" : "refill");
        end

        // symmetry: cur=10/ref=3, then cur=3/ref=10
        add(1, splat(8'd10), 8'd3, 1, 0, "sym_rst");
        for (int k = 1; k <= 10; k++)
            add(0, splat(8'd10), 8'd3, 1, (k == 1) ? 0 : 80 - 3 * min8(k - 2), "sym_a");
        for (int m = 0; m <= 10; m++)
            add(0, splat(8'd3), 8'd10, 1, (m == 0) ? 56 : 7 * min8(m - 1), "sym_b");

        // alignment: cur_i = i, ref 0,1,2,...
        add(1, ramp, 8'd0, 1, 0, "align_rst");
        for (int k = 1; k <= 12; k++) begin
            int e;
            e = (k == 9) ? 7 : (k == 10) ? 0 : (k == 11) ? 8 : 16;
            add(0, ramp, 8'(k - 1), k >= 9, e, "align");
        end

        foreach (vecs[n]) begin
            tick(vecs[n].rst, vecs[n].cur, vecs[n].ref_px);
            if (vecs[n].chk) check(vecs[n].name, vecs[n].exp);
            if (vecs[n].rst) check_internal_zero({vecs[n].name, "_regs"});
        end

        // cur impulse on PE0: visible exactly one result, two edges after it is applied
        tick(1, splat(8'd0), 8'd0);
        for (int k = 0; k < 10; k++) tick(0, splat(8'd0), 8'd0);
        check("cur_idle", 0);
        tick(0, 64'h00000000000000FF, 8'd0);
        check("cur_imp_e0", 0);
        tick(0, splat(8'd0), 8'd0);
        check("cur_imp_e1", 255);
        tick(0, splat(8'd0), 8'd0);
        check("cur_imp_e2", 0);

        // ref impulse walks through all eight PEs
        tick(0, splat(8'd0), 8'd200);
        check("ref_imp_e0", 0);
        tick(0, splat(8'd0), 8'd0);
        check("ref_imp_e1", 0);
        for (int k = 2; k <= 9; k++) begin
            tick(0, splat(8'd0), 8'd0);
            check("ref_imp_walk", 200);
        end
        tick(0, splat(8'd0), 8'd0);
        check("ref_imp_exit", 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
